seq_sub_32bits: RTL and testbench

- Multi-cycle unsigned subtractor, the inverse operation of the team's 32-bit carry-lookahead adder. Computes d = a - b - bi with borrow-out.
- Processes CHUNK bits per clock, LSB chunk first, with a start/ready/done handshake.
- Sits beside the adder in the arithmetic datapath and is verified against a golden-model bench in the same style as the adder bench.

---
 rtl/seq_sub_pkg.sv | 27 ++
 rtl/sub_chunk.sv | 29 ++
 rtl/seq_sub_32bits.sv | 152 +++++++++++++++
 tb/tb_seq_sub_32bits.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_sub_pkg.sv
// -----------------------------------------------------------------------------
// seq_sub_pkg
// Shared definitions for the multi-cycle subtractor.
//   state_t       : controller states (IDLE, RUN, DONE)
//   numChunks()   : number of CHUNK-wide slices that make up a WIDTH-bit word
//   counterWidth(): bits needed to count slices, never less than 1
// -----------------------------------------------------------------------------
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices the operand is split into.
  function automatic int numChunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A one-slice build still needs a 1-bit counter so the register
  // declarations stay legal.
  function automatic int counterWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// -----------------------------------------------------------------------------
// sub_chunk
// Combinational CHUNK-bit subtractor: {bout, diff} = x - y - bin.
//   x    : minuend slice
//   y    : subtrahend slice
//   bin  : borrow in
//   diff : difference slice
//   bout : borrow out
// -----------------------------------------------------------------------------
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic [CHUNK:0] sum;

  // Two's-complement subtraction done as an addition: x + ~y + ~bin.
  // The carry out of that sum is high exactly when no borrow was needed,
  // so the borrow out is its inverse.
  assign sum  = {1'b0, x} + {1'b0, ~y} + {{CHUNK{1'b0}}, ~bin};
  assign diff = sum[CHUNK-1:0];
  assign bout = ~sum[CHUNK];

endmodule

// File: rtl/seq_sub_32bits.sv
// -----------------------------------------------------------------------------
// seq_sub_32bits
// Multi-cycle unsigned subtractor computing d = a - b - bi with borrow out,
// one CHUNK-bit slice per clock, least significant slice first.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, taken on a rising edge while ready is high
//   a, b  : minuend / subtrahend, sampled only on the accepting edge
//   bi    : borrow in, sampled only on the accepting edge
//   ready : a start can be accepted
//   busy  : an operation is in progress
//   d     : registered difference, holds until the next completion
//   bo    : registered borrow out, holds until the next completion
//   done  : one-cycle pulse when d/bo carry a fresh result
// -----------------------------------------------------------------------------
module seq_sub_32bits
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             done
);

  localparam int N     = numChunks(WIDTH, CHUNK);
  localparam int CNT_W = counterWidth(N);

  state_t             state_q;
  logic [WIDTH-1:0]   workA_q;
  logic [WIDTH-1:0]   workB_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   chunkCnt_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_d;
  logic [WIDTH-1:0]   d_q;
  logic               bo_q;
  logic               done_q;
  logic               ready_q;
  logic               busy_q;

  logic [CHUNK-1:0]   chunkA;
  logic [CHUNK-1:0]   chunkB;
  logic [CHUNK-1:0]   chunkDiff;
  logic               chunkBorrow;
  logic               lastChunk;

  // Steer the slice selected by the counter into the single shared
  // slice subtractor.
  always_comb begin
    chunkA = '0;
    chunkB = '0;
    for (int k = 0; k < N; k++) begin
      if (chunkCnt_q == CNT_W'(k)) begin
        chunkA = workA_q[k*CHUNK +: CHUNK];
        chunkB = workB_q[k*CHUNK +: CHUNK];
      end
    end
  end

  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_sub_chunk (
    .x    (chunkA),
    .y    (chunkB),
    .bin  (borrow_q),
    .diff (chunkDiff),
    .bout (chunkBorrow)
  );

  // Result shift register: each new slice enters at the top, so after the
  // last slice the least significant one has reached bit 0.
  generate
    if (N == 1) begin : g_single
      assign result_d = chunkDiff;
    end else begin : g_multi
      assign result_d = {chunkDiff, result_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign lastChunk = (chunkCnt_q == CNT_W'(N - 1));

  // Controller and datapath registers. Outputs are registered here so that
  // ready/busy/done change only on a clock edge (or on reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      workA_q    <= '0;
      workB_q    <= '0;
      borrow_q   <= 1'b0;
      chunkCnt_q <= '0;
      result_q   <= '0;
      d_q        <= '0;
      bo_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            workA_q    <= a;
            workB_q    <= b;
            borrow_q   <= bi;
            chunkCnt_q <= '0;
            result_q   <= '0;
            state_q    <= RUN;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          borrow_q   <= chunkBorrow;
          result_q   <= result_d;
          chunkCnt_q <= chunkCnt_q + CNT_W'(1);
          if (lastChunk) begin
            d_q     <= result_d;
            bo_q    <= chunkBorrow;
            done_q  <= 1'b1;
            state_q <= DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign d     = d_q;
  assign bo    = bo_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_sub_32bits.sv
// -----------------------------------------------------------------------------
// tb_seq_sub_32bits
// Self-checking bench for seq_sub_32bits: directed corner cases, handshake
// behaviour, mid-operation reset, continuous start and random operands
// compared against plain-arithmetic expectations.
// -----------------------------------------------------------------------------
module tb_seq_sub_32bits;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        biIn;
  logic        ready;
  logic        busy;
  logic [31:0] dOut;
  logic        boOut;
  logic        done;

  int testsRun  = 0;
  int failCount = 0;

  seq_sub_32bits #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (aIn),
    .b     (bIn),
    .bi    (biIn),
    .ready (ready),
    .busy  (busy),
    .d     (dOut),
    .bo    (boOut),
    .done  (done)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected difference: plain modular arithmetic on the full word.
  function automatic logic [31:0] refDiff(input logic [31:0] x, input logic [31:0] y, input logic bin);
    return x - y - {31'b0, bin};
  endfunction

  // Expected borrow: the minuend is smaller than what is taken from it.
  function automatic logic refBorrow(input logic [31:0] x, input logic [31:0] y, input logic bin);
    longint unsigned lhs;
    longint unsigned rhs;
    lhs = longint'(x);
    rhs = longint'(y) + longint'(bin);
    return (lhs < rhs);
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Run one operation from an idle controller and check latency, busy
  // duration, result, and that done lasts exactly one cycle.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input logic opBi, input string name);
    int cycles;
    int busyCycles;
    @(negedge clk);
    aIn   = opA;
    bIn   = opB;
    biIn  = opBi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aIn   = $urandom;
    bIn   = $urandom;
    biIn  = 1'($urandom);
    cycles     = 0;
    busyCycles = 0;
    while (!done && cycles < 20) begin
      if (busy) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    checkOutput($sformatf("%s latency", name), 64'(cycles), 64'd4);
    checkOutput($sformatf("%s busy", name), 64'(busyCycles), 64'd4);
    checkOutput($sformatf("%s d", name), 64'(dOut), 64'(refDiff(opA, opB, opBi)));
    checkOutput($sformatf("%s bo", name), 64'(boOut), 64'(refBorrow(opA, opB, opBi)));
    @(negedge clk);
    checkOutput($sformatf("%s done width", name), 64'(done), 64'd0);
    checkOutput($sformatf("%s ready after", name), 64'(ready), 64'd1);
  endtask

  // Main sequence.
  initial begin
    logic [31:0] opA;
    logic [31:0] opB;
    logic        opBi;
    logic [31:0] firstA;
    logic [31:0] firstB;
    int          cycles;
    int          gap;
    bit          sawDone;

    rst_n = 1'b0;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
    biIn  = 1'b0;

    // Reset for three cycles, then release.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset d", 64'(dOut), 64'd0);
    checkOutput("reset bo", 64'(boOut), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset ready", 64'(ready), 64'd1);

    // Directed corner cases.
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0, "ripple");
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, "msb");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "allones");

    // Start pulsed while running must not disturb the first operation.
    firstA = 32'h1234_5678;
    firstB = 32'h0F0F_0F0F;
    @(negedge clk);
    aIn   = firstA;
    bIn   = firstB;
    biIn  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    aIn   = 32'hDEAD_BEEF;
    bIn   = 32'h0000_0001;
    biIn  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 2;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("runstart latency", 64'(cycles), 64'd4);
    checkOutput("runstart d", 64'(dOut), 64'(refDiff(firstA, firstB, 1'b1)));
    checkOutput("runstart bo", 64'(boOut), 64'(refBorrow(firstA, firstB, 1'b1)));
    @(negedge clk);
    checkOutput("runstart idle ready", 64'(ready), 64'd1);
    checkOutput("runstart idle busy", 64'(busy), 64'd0);

    // Reset two cycles into an operation: outputs clear at once, no done.
    @(negedge clk);
    aIn   = 32'h0000_0005;
    bIn   = 32'h0000_0003;
    biIn  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset d", 64'(dOut), 64'd0);
    checkOutput("midreset bo", 64'(boOut), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset ready", 64'(ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("midreset no done", 64'(sawDone), 64'd0);

    // Start held high: a new operation is taken in every DONE cycle.
    opA  = $urandom;
    opB  = $urandom;
    opBi = 1'($urandom);
    @(negedge clk);
    aIn   = opA;
    bIn   = opB;
    biIn  = opBi;
    start = 1'b1;
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("held first done", 64'(done), 64'd1);
    for (int op = 0; op < 6; op++) begin
      checkOutput($sformatf("held d %0d", op), 64'(dOut), 64'(refDiff(opA, opB, opBi)));
      checkOutput($sformatf("held bo %0d", op), 64'(boOut), 64'(refBorrow(opA, opB, opBi)));
      opA  = $urandom;
      opB  = $urandom;
      opBi = 1'($urandom);
      aIn  = opA;
      bIn  = opB;
      biIn = opBi;
      gap  = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 20);
      checkOutput($sformatf("held gap %0d", op), 64'(gap), 64'd5);
    end
    checkOutput("held last d", 64'(dOut), 64'(refDiff(opA, opB, opBi)));
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Random operands, including forced extremes now and then.
    for (int i = 0; i < 1000; i++) begin
      opA  = $urandom;
      opB  = $urandom;
      opBi = 1'($urandom);
      if ($urandom_range(0, 9) == 0) opA = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
      if ($urandom_range(0, 9) == 0) opB = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
      if ($urandom_range(0, 9) == 0) opB = opA;
      applyStimulus(opA, opB, opBi, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
